// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i pipeline control path.
// Holds the hazard controller state encoding and the ALU operand-forward selects.
// No logic; imported by the controller and its forwarding sub-block.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    MEM_WAIT  = 2'd2,
    ERROR     = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one E-stage source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the select is honoured.
module fwd_sel
  import rv32i_pkg::*;
#(
  parameter int REG_WIDTH = 5
) (
  input  logic [REG_WIDTH-1:0] rs,
  input  logic [REG_WIDTH-1:0] rd_m,
  input  logic [REG_WIDTH-1:0] rd_w,
  input  logic                 regwrite_m,
  input  logic                 regwrite_w,
  output logic [1:0]           sel
);

  // M is the younger producer, so it overrides W; x0 never forwards.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_w && (rd_w != '0) && (rd_w == rs)) sel = FWD_W;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) sel = FWD_M;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/forward controller for the 5-stage rv32i pipeline.
// Latency: stall/flush/forward outputs are same-cycle; state, mem_err, stall_cycles registered.
// Backpressure: a memory wait freezes F..M and bubbles W; a watchdog latches a sticky error.
module pipeline_ctrl
  import rv32i_pkg::*;
#(
  parameter int REG_WIDTH   = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memreadE,
  input  logic [REG_WIDTH-1:0] Rs1D,
  input  logic [REG_WIDTH-1:0] Rs2D,
  input  logic [REG_WIDTH-1:0] Rs1E,
  input  logic [REG_WIDTH-1:0] Rs2E,
  input  logic [REG_WIDTH-1:0] RdE,
  input  logic [REG_WIDTH-1:0] RdM,
  input  logic [REG_WIDTH-1:0] RdW,
  input  logic                 regwriteM,
  input  logic                 regwriteW,
  input  logic                 pc_srcE,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushW,
  output logic [1:0]           fwdAE,
  output logic [1:0]           fwdBE,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  // Wide enough to hold MEM_TIMEOUT itself, so the +1 never wraps.
  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

  ctrl_state_t          state_q, state_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic       memwait;
  logic       lwstall;
  logic       active;
  logic [1:0] sel_a, sel_b;

  assign memwait = dmem_req & ~dmem_ready;
  assign lwstall = memreadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign active  = (state_q == RUN) || (state_q == MEM_WAIT);

  fwd_sel #(.REG_WIDTH(REG_WIDTH)) u_fwd_a (
    .rs         (Rs1E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .regwrite_m (regwriteM),
    .regwrite_w (regwriteW),
    .sel        (sel_a)
  );

  fwd_sel #(.REG_WIDTH(REG_WIDTH)) u_fwd_b (
    .rs         (Rs2E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .regwrite_m (regwriteM),
    .regwrite_w (regwriteW),
    .sel        (sel_b)
  );

  // Per-stage controls: fixed patterns in RST_FLUSH/ERROR, prioritised hazards otherwise.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    fwdAE  = FWD_RF;
    fwdBE  = FWD_RF;
    case (state_q)
      RST_FLUSH: begin
        stallF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        flushW = 1'b1;
      end
      ERROR: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end
      default: begin
        fwdAE = sel_a;
        fwdBE = sel_b;
        if (memwait) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
          flushW = 1'b1;
        end else if (pc_srcE) begin
          // Redirect squashes the load-use victim too, so no stall is needed.
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (lwstall) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
    endcase
  end

  // Next-state: flush-once after reset, memory-wait tracking with watchdog, stall counting.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      RST_FLUSH: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      ERROR: begin
        state_d   = ERROR;
        mem_err_d = 1'b1;
      end
      default: begin
        if (memwait) begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
          if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end
        if (stallD && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
      end
    endcase
  end

  // Controller state register; reset lands in RST_FLUSH without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RST_FLUSH;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule
